// File: rtl/memory_access_stage.sv
// EX/MEM stage: latches an instruction from execute and performs its data
// memory access through a req/ack handshake. It then hands the result to
// writeback through a valid/ready handshake.
module memory_access_stage #(
    parameter int          DATA_W     = 16,
    parameter logic [3:0]  OP_STORE   = 4'b1100,
    parameter logic [3:0]  OP_LOAD    = 4'b1011,
    parameter logic [3:0]  OP_COPY_IN = 4'b1111
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [19:0]       in_instruction,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_input_addr,
    input  logic [DATA_W-1:0] in_store_data,
    input  logic              flush,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [19:0]       out_instruction,
    output logic [DATA_W-1:0] out_data,
    output logic [15:0]       stall_count
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state_reg;
    logic        kill_reg;
    logic [19:0] held_instr_reg;

    logic [3:0]  opcode;
    logic        is_mem_op;
    logic        accept;

    assign opcode    = in_instruction[19:16];
    assign is_mem_op = (opcode == OP_STORE) || (opcode == OP_LOAD) || (opcode == OP_COPY_IN);

    // Only take a new instruction when idle and the result slot is free
    // or draining this cycle; flush blocks acceptance outright.
    assign in_ready = (state_reg == IDLE) && (!out_valid || out_ready) && !flush;
    assign accept   = in_valid && in_ready;

    // Main control: accept, memory handshake, result register and kill tracking.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            kill_reg        <= 1'b0;
            held_instr_reg  <= '0;
            mem_req         <= 1'b0;
            mem_we          <= 1'b0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            out_valid       <= 1'b0;
            out_instruction <= '0;
            out_data        <= '0;
        end else begin
            // A delivered or flushed result leaves the register; a new
            // result loaded below at the same edge overrides this.
            if (out_valid && (out_ready || flush)) begin
                out_valid <= 1'b0;
            end

            if (accept) begin
                if (is_mem_op) begin
                    state_reg      <= ACCESS;
                    kill_reg       <= 1'b0;
                    held_instr_reg <= in_instruction;
                    mem_req        <= 1'b1;
                    mem_we         <= (opcode == OP_STORE);
                    mem_addr       <= (opcode == OP_COPY_IN) ? in_input_addr : in_alu_result;
                    mem_wdata      <= in_store_data;
                end else begin
                    out_valid       <= 1'b1;
                    out_instruction <= in_instruction;
                    out_data        <= in_alu_result;
                end
            end else if (state_reg == ACCESS) begin
                // The request is never withdrawn; a flush only marks the
                // result for discard so a killed STORE still writes.
                if (flush) begin
                    kill_reg <= 1'b1;
                end
                if (mem_ack) begin
                    state_reg <= IDLE;
                    kill_reg  <= 1'b0;
                    mem_req   <= 1'b0;
                    mem_we    <= 1'b0;
                    if (!kill_reg && !flush) begin
                        out_valid       <= 1'b1;
                        out_instruction <= held_instr_reg;
                        // mem_we is still high here only for a STORE, whose
                        // result is the address it wrote.
                        out_data        <= mem_we ? mem_addr : mem_rdata;
                    end
                end
            end
        end
    end

    // Saturating count of cycles where execute is held off.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
        end else if (in_valid && !in_ready && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage: one task per scenario.
`timescale 1ns/1ps
module tb_memory_access_stage;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] in_instruction;
    logic [15:0] in_alu_result;
    logic [15:0] in_input_addr;
    logic [15:0] in_store_data;
    logic        flush;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_instruction;
    logic [15:0] out_data;
    logic [15:0] stall_count;

    int checks;
    int failures;

    memory_access_stage dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instruction(in_instruction), .in_alu_result(in_alu_result),
        .in_input_addr(in_input_addr), .in_store_data(in_store_data),
        .flush(flush),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instruction(out_instruction), .out_data(out_data),
        .stall_count(stall_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge and settle.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid       = 1'b0;
        in_instruction = '0;
        in_alu_result  = '0;
        in_input_addr  = '0;
        in_store_data  = '0;
        flush          = 1'b0;
        mem_rdata      = '0;
        mem_ack        = 1'b0;
        out_ready      = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        #2;
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, out_valid, out_instruction, out_data, stall_count} !== '0) begin
            failures++;
            $display("FAIL reset_state: outputs not all zero");
        end
        tick();
        reset = 1'b1;
        tick();
        // Start a LOAD and assert reset while it is outstanding.
        in_valid = 1'b1; in_instruction = 20'hB_0000; in_alu_result = 16'h0021;
        tick();
        in_valid = 1'b0;
        checks++;
        if (mem_req !== 1'b1) begin
            failures++;
            $display("FAIL reset_pre_access: mem_req=%b expected 1", mem_req);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || mem_addr !== 16'h0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_access: req=%b addr=%h ov=%b rdy=%b expected 0 0000 0 1",
                     mem_req, mem_addr, out_valid, in_ready);
        end
        tick();
        reset = 1'b1;
        tick();
        in_valid = 1'b1; in_instruction = 20'h0_0123; in_alu_result = 16'h0042; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h0042 || out_instruction !== 20'h0_0123) begin
            failures++;
            $display("FAIL reset_passthru: ov=%b data=%h instr=%h expected 1 0042 00123",
                     out_valid, out_data, out_instruction);
        end
        $display("test_reset done");
    endtask

    task automatic test_store();
        do_reset();
        in_valid = 1'b1; in_instruction = 20'hC_0000; in_alu_result = 16'h0010; in_store_data = 16'hBEEF;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL store_accept_ready: in_ready=%b expected 1", in_ready);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h0010 || mem_wdata !== 16'hBEEF || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL store_hold cycle %0d: req=%b we=%b addr=%h wdata=%h rdy=%b expected 1 1 0010 beef 0",
                         i, mem_req, mem_we, mem_addr, mem_wdata, in_ready);
            end
            mem_ack = (i == 2);
            tick();
        end
        mem_ack = 1'b0; in_valid = 1'b0;
        checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || out_valid !== 1'b1 || out_data !== 16'h0010 ||
            out_instruction !== 20'hC_0000 || stall_count !== 16'd3) begin
            failures++;
            $display("FAIL store_done: req=%b we=%b ov=%b data=%h instr=%h stalls=%0d expected 0 0 1 0010 c0000 3",
                     mem_req, mem_we, out_valid, out_data, out_instruction, stall_count);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL store_consumed: ov=%b expected 0", out_valid);
        end
        $display("test_store done");
    endtask

    task automatic test_copy_in();
        do_reset();
        in_valid = 1'b1; in_instruction = 20'hF_0000; in_input_addr = 16'h0080; in_alu_result = 16'h0001;
        tick();
        in_valid = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0080) begin
            failures++;
            $display("FAIL copy_in_req: req=%b we=%b addr=%h expected 1 0 0080", mem_req, mem_we, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 16'h1234;
        tick();
        mem_ack = 1'b0; mem_rdata = 16'h0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h1234 || out_instruction !== 20'hF_0000 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL copy_in_result: ov=%b data=%h instr=%h req=%b expected 1 1234 f0000 0",
                     out_valid, out_data, out_instruction, mem_req);
        end
        $display("test_copy_in done");
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_instruction = 20'h0_0010 + 20'(i); in_alu_result = 16'h0100 + 16'(i);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready %0d: in_ready=%b expected 1", i, in_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== (16'h0100 + 16'(i))) begin
                failures++;
                $display("FAIL b2b_result %0d: ov=%b data=%h expected 1 %h", i, out_valid, out_data, 16'h0100 + 16'(i));
            end
        end
        in_instruction = 20'h0_0020; in_alu_result = 16'h0200; out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                failures++;
                $display("FAIL b2b_backpressure_ready %0d: in_ready=%b expected 0", i, in_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 16'h0103 || out_instruction !== 20'h0_0013) begin
                failures++;
                $display("FAIL b2b_hold %0d: ov=%b data=%h instr=%h expected 1 0103 00013",
                         i, out_valid, out_data, out_instruction);
            end
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h0200 || stall_count !== 16'd2) begin
            failures++;
            $display("FAIL b2b_resume: ov=%b data=%h stalls=%0d expected 1 0200 2", out_valid, out_data, stall_count);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain: ov=%b expected 0", out_valid);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_flush();
        do_reset();
        in_valid = 1'b1; in_instruction = 20'hB_0000; in_alu_result = 16'h0044;
        tick();
        in_valid = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0044) begin
            failures++;
            $display("FAIL flush_load_req: req=%b we=%b addr=%h expected 1 0 0044", mem_req, mem_we, mem_addr);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== 16'h0044) begin
                failures++;
                $display("FAIL flush_req_held %0d: req=%b addr=%h expected 1 0044", i, mem_req, mem_addr);
            end
            tick();
        end
        mem_ack = 1'b1; mem_rdata = 16'h5555;
        tick();
        mem_ack = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL flush_killed: ov=%b req=%b expected 0 0", out_valid, mem_req);
        end
        // Pending pass-through result flushed while writeback is ready.
        out_ready = 1'b0;
        in_valid = 1'b1; in_instruction = 20'h0_0777; in_alu_result = 16'h0777;
        tick();
        flush = 1'b1; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL flush_block_ready: rdy=%b ov=%b expected 0 1", in_ready, out_valid);
        end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_pending: ov=%b expected 0", out_valid);
        end
        // Stray ack while idle must not create a result.
        mem_ack = 1'b1; mem_rdata = 16'h9999;
        tick();
        mem_ack = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL idle_ack: ov=%b req=%b expected 0 0", out_valid, mem_req);
        end
        $display("test_flush done");
    endtask

    task automatic test_saturation();
        do_reset();
        flush = 1'b1; in_valid = 1'b1;
        repeat (65534) @(posedge clock);
        #1;
        checks++;
        if (stall_count !== 16'hFFFE) begin
            failures++;
            $display("FAIL sat_before: stall_count=%h expected fffe", stall_count);
        end
        tick();
        checks++;
        if (stall_count !== 16'hFFFF) begin
            failures++;
            $display("FAIL sat_reach: stall_count=%h expected ffff", stall_count);
        end
        repeat (4465) @(posedge clock);
        #1;
        checks++;
        if (stall_count !== 16'hFFFF) begin
            failures++;
            $display("FAIL sat_hold: stall_count=%h expected ffff", stall_count);
        end
        idle_inputs();
        $display("test_saturation done");
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b0;
        idle_inputs();
        #3;
        test_reset();
        test_store();
        test_copy_in();
        test_back_to_back();
        test_flush();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memory_access_stage.md
Name: memory_access_stage

Overview:
- EX/MEM pipeline stage of the 20-bit-instruction pipeline processor.
- Latches an instruction plus operands from execute and decodes it: STORE writes memory, LOAD reads memory, COPY INPUT takes its address from the input-address operand.
- Drives the data-memory request/acknowledge handshake and stalls execute while an access is outstanding.
- Presents the result to writeback with a valid/ready handshake.

Parameters:
- DATA_W, 16, width of data, address and result words
- OP_STORE, 4'b1100, opcode (instruction[19:16]) of STORE
- OP_LOAD, 4'b1011, opcode of LOAD
- OP_COPY_IN, 4'b1111, opcode of COPY INPUT

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  execute offers an instruction
- in_ready  out  1  stage accepts this cycle
- in_instruction  in  20  instruction word
- in_alu_result  in  DATA_W  ALU result; the address for LOAD/STORE
- in_input_addr  in  DATA_W  address used by COPY INPUT
- in_store_data  in  DATA_W  STORE write data
- flush  in  1  kill the held, not yet delivered instruction
- mem_req  out  1  memory request
- mem_we  out  1  write strobe, qualified by mem_req
- mem_addr  out  DATA_W  memory address
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- mem_ack  in  1  access complete, one-cycle pulse
- out_valid  out  1  result available to writeback
- out_ready  in  1  writeback accepts
- out_instruction  out  20  delivered instruction
- out_data  out  DATA_W  LOAD/COPY INPUT: read data; others: ALU result
- stall_count  out  16  saturating count of cycles with in_valid=1 and in_ready=0

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; kill flag cleared
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0
  - out_valid=0, out_instruction=0, out_data=0, stall_count=0
  - Asserting reset mid-access abandons the access.
- Accept condition: in_valid && in_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready). The output register frees in the same cycle it is consumed.
- Memory op: opcode is LOAD, STORE or COPY_IN. All other opcodes are pass-through.
- Pass-through accepted at edge N: out_valid=1, out_data=in_alu_result from edge N. Latency 1, full throughput.
- Memory op accepted at edge N:
  - state goes to ACCESS.
  - mem_req=1 from edge N.
  - mem_we=1 only for STORE.
  - mem_addr = in_input_addr for COPY_IN, else in_alu_result.
  - mem_wdata = in_store_data.
  - Instruction and operands are held internally.
- ACCESS:
  - mem_req, mem_we, mem_addr and mem_wdata stay stable until the edge that samples mem_ack=1.
  - At that edge: mem_req=0, mem_we=0, state goes to IDLE.
  - Unless killed, at that same edge: out_valid=1, out_instruction=held instruction, out_data = mem_rdata (LOAD/COPY_IN) or the held address (STORE).
  - Minimum memory-op latency: acceptance to out_valid is 2 edges when mem_ack arrives in the first request cycle.
- Entry into ACCESS is legal only when the output register is empty or being consumed, so the result register is always free when mem_ack arrives.
- Output hold: out_valid and its data stay stable until the edge where out_ready=1, then clear unless a new result is loaded at the same edge.
- flush:
  - IDLE with out_valid=1 and no acceptance: out_valid clears at the next edge.
  - ACCESS: mem_req stays asserted until mem_ack; it is never withdrawn. The kill flag is set, and at ack the result is discarded (out_valid stays 0). A killed STORE still writes memory.
  - Inputs are not accepted while flush=1; in_ready is forced to 0.
  - flush and out_ready together on a valid output: the flush wins and nothing is delivered.
- mem_ack while in IDLE is ignored.
- stall_count increments on every cycle with in_valid=1 and in_ready=0, saturating at 16'hFFFF with no wrap.

Test Plan:
- Reset: drive reset=0 mid-ACCESS → all outputs 0 immediately, state IDLE. Release reset, then instruction 20'h0_0123, alu 16'h0042 → out_valid at next edge, out_data 16'h0042.
- STORE 20'hC_0000, alu 16'h0010, data 16'hBEEF, mem_ack 3 cycles later → mem_req/mem_we/addr 16'h0010/wdata 16'hBEEF stable 3 cycles; in_ready=0; stall_count=3; out_valid one edge after ack.
- COPY INPUT 20'hF_0000, input_addr 16'h0080, alu 16'h0001, rdata 16'h1234 → mem_addr 16'h0080, mem_we=0, out_data 16'h1234.
- Back-to-back pass-through with out_ready=1 → one result per cycle. Drop out_ready for 2 cycles → in_ready=0, output held stable.
- flush during LOAD ACCESS → mem_req held until ack; no out_valid. flush with pending output and out_ready=1 → no delivery.
- Force 70000 stall cycles → stall_count saturates at 16'hFFFF.
